// File: rtl/rsa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rsa_pkg                                                          |
// | Brief   : Shared constants and types for the RSA exponentiation scheduler. |
// |           Default key material (n = 53 * 67, e, d), request mode encodings |
// |           and the scheduler state enumeration.                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package rsa_pkg;

    // Toy key pair: n = 3551 = 53 * 67, phi = 3432, e * d = 6865 = 2 * phi + 1
    localparam int unsigned N_MOD_DEFAULT       = 3551;
    localparam int unsigned E_EXP_DEFAULT       = 5;
    localparam int unsigned D_EXP_DEFAULT       = 1373;
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 4096;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rsa_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rsa_rr_arb2                                                      |
// | Brief   : Two-requester round-robin arbiter. A lone valid requester wins;  |
// |           with both valid the one not served last wins. The pointer only   |
// |           moves when the caller signals an accepted grant via advance.     |
// | Ports   : clk, res (sync, active-low), valid[1:0], advance, grant[1:0]     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module rsa_rr_arb2 (
    input  logic       clk,
    input  logic       res,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    // Index of the port served most recently; reset to 1 so port 0 is favoured.
    logic r_last;

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            r_last <= 1'b1;
        end else if (advance) begin
            r_last <= grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/rsa_exp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rsa_exp_scheduler                                                |
// | Brief   : Shares one start/done modular-exponentiation engine between two  |
// |           request ports. Selects e or d by request mode, launches the      |
// |           engine, waits for done and returns result plus requester id on a |
// |           single response channel. One job in flight at a time.            |
// | Ports   : clk, res (sync, active-low)                                      |
// |           req0_*/req1_* : valid/ready/mode/data request ports              |
// |           rsp_*         : valid/ready/id/err/data response channel         |
// |           eng_*         : start/base/exp/mod/abort/done/result engine i/f  |
// | Config  : RSA_SCHED_TIMEOUT_EN enables the engine watchdog (TIMEOUT_CYC)   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module rsa_exp_scheduler #(
    parameter int unsigned N_MOD       = rsa_pkg::N_MOD_DEFAULT,
    parameter int unsigned E_EXP       = rsa_pkg::E_EXP_DEFAULT,
    parameter int unsigned D_EXP       = rsa_pkg::D_EXP_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = rsa_pkg::TIMEOUT_CYC_DEFAULT
) (
    input  logic        clk,
    input  logic        res,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_mode,
    input  logic [15:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_mode,
    input  logic [15:0] req1_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic [15:0] rsp_data,
    output logic        eng_start,
    output logic [15:0] eng_base,
    output logic [15:0] eng_exp,
    output logic [15:0] eng_mod,
    output logic        eng_abort,
    input  logic        eng_done,
    input  logic [15:0] eng_result
);

    import rsa_pkg::*;

    localparam logic [15:0] c_n_mod = 16'(N_MOD);
    localparam logic [15:0] c_e_exp = 16'(E_EXP);
    localparam logic [15:0] c_d_exp = 16'(D_EXP);

    sched_state_t r_state;
    sched_state_t w_next_state;

    logic [1:0]  w_grant;
    logic        w_accept;
    logic        w_reject;
    logic        w_timeout;
    logic [15:0] w_sel_data;
    logic        w_sel_mode;

    rsa_rr_arb2 u_arb (
        .clk     (clk),
        .res     (res),
        .valid   ({req1_valid, req0_valid}),
        .advance (w_accept),
        .grant   (w_grant)
    );

    assign w_sel_data = w_grant[1] ? req1_data : req0_data;
    assign w_sel_mode = w_grant[1] ? req1_mode : req0_mode;
    // Bases outside [0, n) are not valid residues; answer them without the engine.
    assign w_reject   = (w_sel_data >= c_n_mod);

    assign rsp_valid  = (r_state == ST_RESP);
    assign eng_mod    = c_n_mod;

    always_ff @(posedge clk) begin
        if (!res) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        eng_start    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req0_ready = w_grant[0] & ~rsp_valid;
                req1_ready = w_grant[1] & ~rsp_valid;
                w_accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
                if (w_accept) begin
                    w_next_state = w_reject ? ST_RESP : ST_START;
                end
            end
            ST_START: begin
                eng_start    = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done || w_timeout) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Job operands are captured at accept so later requester changes are ignored;
    // they stay put through START and WAIT, which keeps them stable for the engine.
    always_ff @(posedge clk) begin
        if (!res) begin
            eng_base <= '0;
            eng_exp  <= '0;
            rsp_id   <= 1'b0;
            rsp_err  <= 1'b0;
            rsp_data <= '0;
        end else begin
            if (w_accept) begin
                eng_base <= w_sel_data;
                eng_exp  <= (w_sel_mode == MODE_DEC) ? c_d_exp : c_e_exp;
                rsp_id   <= w_grant[1];
                if (w_reject) begin
                    rsp_err  <= 1'b1;
                    rsp_data <= '0;
                end
            end
            if (r_state == ST_WAIT) begin
                if (eng_done) begin
                    rsp_data <= eng_result;
                    rsp_err  <= 1'b0;
                end else if (w_timeout) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end
            end
        end
    end

`ifdef RSA_SCHED_TIMEOUT_EN
    localparam logic [15:0] c_to_last = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_to_cnt;

    // Cleared in START so the first WAIT cycle reads 0; the TIMEOUT_CYC-th WAIT
    // cycle without done fires the abort. A same-cycle done takes priority.
    always_ff @(posedge clk) begin
        if (!res) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_START) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && !eng_done && (r_to_cnt == c_to_last);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |16'(TIMEOUT_CYC);
    assign w_timeout        = 1'b0;
`endif

    assign eng_abort = w_timeout;

endmodule
`default_nettype wire
